kernel_dispatcher: RTL

Bus-side transmitter that loads per-column filter weights into the PE-array MultiCasters. On a start request it broadcasts column tags, then for each column in turn issues a kernel-size flush and streams that column's weights with the column ID driven. It respects the MultiCasters' `kernel_busy` back-pressure and sits between the weight source (global buffer/DMA) and the column bus.

---
 rtl/kernel_dispatcher.sv | 132 +++++++++++++
 1 files changed

// File: rtl/kernel_dispatcher.sv
// Column-bus weight loader: broadcasts column tags, then flushes and streams
// kernel_size weights into each PE-array MultiCaster in turn.
module kernel_dispatcher #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned MAX_KERNEL = 16,
  localparam int unsigned TW        = $clog2(NUM_COL) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [7:0]              kernel_size_in,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic                    kernel_busy,
  output logic                    flush_tag,
  output logic [NUM_COL*TW-1:0]   tag_vec,
  output logic                    flush_kernel,
  output logic [7:0]              kernel_size_out,
  output logic [TW-1:0]           ID,
  output logic [DATA_WIDTH-1:0]   fltr_data,
  output logic                    fltr_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [2:0] {IDLE, TAG, KFLUSH, STREAM, DONE} state_t;

  state_t          state, state_n;
  logic [7:0]      ks_n;
  logic [7:0]      w_cnt, w_cnt_n;
  logic [TW-1:0]   col_cnt, col_cnt_n;
  logic [TW-1:0]   id_n;
  logic            hs;
  logic            err_n;

  // Each column's tag is its own index; the MultiCasters match against it.
  for (genvar c = 0; c < NUM_COL; c++) begin : g_tag
    assign tag_vec[c*TW +: TW] = TW'(c);
  end

  // Next-state, counters and the combinational stream handshake.
  always_comb begin
    state_n   = state;
    ks_n      = kernel_size_out;
    w_cnt_n   = w_cnt;
    col_cnt_n = col_cnt;
    err_n     = 1'b0;
    w_ready   = 1'b0;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (kernel_size_in != 8'd0 && kernel_size_in <= 8'(MAX_KERNEL)) begin
            ks_n      = kernel_size_in;
            col_cnt_n = '0;
            state_n   = TAG;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      TAG:    state_n = KFLUSH;
      KFLUSH: begin
        w_cnt_n = '0;
        state_n = STREAM;
      end
      STREAM: begin
        w_ready = ~kernel_busy;
        hs      = w_valid & ~kernel_busy;
        if (hs) begin
          w_cnt_n = w_cnt + 8'd1;
          if (w_cnt == kernel_size_out - 8'd1) begin
            if (col_cnt == TW'(NUM_COL - 1)) begin
              state_n = DONE;
            end else begin
              col_cnt_n = col_cnt + TW'(1);
              state_n   = KFLUSH;
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The final column's trailing word keeps its column ID for one extra cycle.
  always_comb begin
    id_n = TW'(NUM_COL);
    if (state_n == KFLUSH || state_n == STREAM) begin
      id_n = col_cnt_n;
    end else if (state == STREAM && state_n == DONE) begin
      id_n = col_cnt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      kernel_size_out <= '0;
      w_cnt           <= '0;
      col_cnt         <= '0;
      flush_tag       <= 1'b0;
      flush_kernel    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      ID              <= TW'(NUM_COL);
      fltr_valid      <= 1'b0;
      fltr_data       <= '0;
    end else begin
      state           <= state_n;
      kernel_size_out <= ks_n;
      w_cnt           <= w_cnt_n;
      col_cnt         <= col_cnt_n;
      flush_tag       <= (state_n == TAG);
      flush_kernel    <= (state_n == KFLUSH);
      busy            <= (state_n != IDLE);
      done            <= (state == DONE);
      err             <= err_n;
      ID              <= id_n;
      fltr_valid      <= hs;
      if (hs) begin
        fltr_data <= w_data;
      end
    end
  end

endmodule
